// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: FSM encoding, block geometry, FIPS-197 vectors
// and the byte-level transforms used by the round datapaths.
package aes128_pkg;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [127:0] FIPS_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse is b^254 (zero maps to zero), followed by the affine transform.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sub_byte(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte index = row + 4*column; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expansion(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sub_byte(w3[23:16]), sub_byte(w3[15:8]), sub_byte(w3[7:0]), sub_byte(w3[31:24])}
         ^ {rcon(rc), 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes128_final_round.sv
// Last AES round: same as a full round but without MixColumns.
module aes128_final_round
  import aes128_pkg::*;
#(
  parameter int RC_W = 4
) (
  input  logic [127:0]    data,
  input  logic [127:0]    key_in,
  input  logic [RC_W-1:0] rc,
  output logic [127:0]    key_out,
  output logic [127:0]    rndout
);

  always_comb begin
    key_out = key_expansion(key_in, rc);
    rndout  = shift_rows(sub_bytes(data)) ^ key_out;
  end

endmodule

// File: rtl/round.sv
// Full AES round (rounds 1-9): SubBytes, ShiftRows, MixColumns, AddRoundKey,
// with the next round key expanded from key_in using rcon index rc.
module round
  import aes128_pkg::*;
#(
  parameter int RC_W = 4
) (
  input  logic [127:0]    data,
  input  logic [127:0]    key_in,
  input  logic [RC_W-1:0] rc,
  output logic [127:0]    key_out,
  output logic [127:0]    rndout
);

  always_comb begin
    key_out = key_expansion(key_in, rc);
    rndout  = mix_columns(shift_rows(sub_bytes(data))) ^ key_out;
  end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encrypt core: one shared round datapath reused for rounds
// 1-9, a final-round path for round 10, valid/ready on both sides.
module aes128_iter_ctrl
  import aes128_pkg::*;
#(
  parameter int ROUNDS = 10,
  parameter int RC_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [BLOCK_W-1:0] key,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               busy,
  output logic [RC_W-1:0]    round_idx
);

  localparam logic [RC_W-1:0] LAST_CNT = RC_W'(NR);

  if (ROUNDS != NR) begin : g_bad_rounds
    $error("aes128_iter_ctrl supports only ROUNDS == 10");
  end

  state_t             state;
  logic [BLOCK_W-1:0] state_reg, key_reg;
  logic [BLOCK_W-1:0] round_data, round_key, final_data, final_key;
  logic [BLOCK_W-1:0] next_data, next_key;
  logic [RC_W-1:0]    cnt, rc;
  logic               accept, last;

  // Outside ROUND cnt is 0 and rc wraps, but the datapath result is then ignored.
  assign rc        = cnt - RC_W'(1);
  assign last      = (cnt == LAST_CNT);
  assign in_ready  = !rst && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready && !abort;
  assign busy      = (state == S_ROUND);
  assign round_idx = cnt;

  round #(.RC_W(RC_W)) u_round (
    .data    (state_reg),
    .key_in  (key_reg),
    .rc      (rc),
    .key_out (round_key),
    .rndout  (round_data)
  );

  aes128_final_round #(.RC_W(RC_W)) u_final (
    .data    (state_reg),
    .key_in  (key_reg),
    .rc      (rc),
    .key_out (final_key),
    .rndout  (final_data)
  );

  // Select the final-round path on round 10
  always_comb begin
    if (last) begin
      next_data = final_data;
      next_key  = final_key;
    end else begin
      next_data = round_data;
      next_key  = round_key;
    end
  end

  // Control FSM with state, key and ciphertext registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      state_reg  <= {BLOCK_W{1'b0}};
      key_reg    <= {BLOCK_W{1'b0}};
      cnt        <= {RC_W{1'b0}};
      out_valid  <= 1'b0;
      ciphertext <= {BLOCK_W{1'b0}};
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state_reg <= plaintext ^ key;
            key_reg   <= key;
            cnt       <= RC_W'(1);
            state     <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= {RC_W{1'b0}};
          end else if (last) begin
            ciphertext <= next_data;
            out_valid  <= 1'b1;
            state      <= S_DONE;
            cnt        <= {RC_W{1'b0}};
          end else begin
            state_reg <= next_data;
            key_reg   <= next_key;
            cnt       <= cnt + RC_W'(1);
          end
        end
        S_DONE: begin
          if (abort) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end else if (accept) begin
            // Output consumed and next block loaded on the same edge
            state_reg <= plaintext ^ key;
            key_reg   <= key;
            cnt       <= RC_W'(1);
            out_valid <= 1'b0;
            state     <= S_ROUND;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          cnt       <= {RC_W{1'b0}};
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Scoreboard bench for aes128_iter_ctrl: FIPS-197 vectors, handshake corner
// cases, abort/reset, and random blocks against a table-driven AES model.
module tb_aes128_iter_ctrl;
  import aes128_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round_idx;

  aes128_iter_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round_idx  (round_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] tb_xt(input logic [7:0] b);
    return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = tb_xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox[x] = s;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcv;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rcv = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcv, 24'h000000};
        rcv = tb_xt(rcv);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ k[127-8*j -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) u[j] = sbox[s[j]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = u[row + 4*((c+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = tb_gm(8'h02, a0) ^ tb_gm(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ tb_gm(8'h02, a1) ^ tb_gm(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ tb_gm(8'h02, a2) ^ tb_gm(8'h03, a3);
          s[4*c+3] = tb_gm(8'h03, a0) ^ a1 ^ a2 ^ tb_gm(8'h02, a3);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = s[row+4*c] ^ w[4*r+c][31-8*row -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;
  exp_t exp_q[$];

  logic         hold   = 1'b0;
  logic         took   = 1'b0;
  logic [127:0] cur_ct = 128'h0;

  // Pops one expectation per presented result; checks value, latency, stability.
  always @(negedge clk) begin
    if (rst) begin
      hold <= 1'b0;
      took <= 1'b0;
    end else begin
      if (took) check("ov_drop_after_take", {127'h0, out_valid}, 128'h0);
      if (out_valid) begin
        if (!hold) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", {127'h0, out_valid}, 128'h0);
          end else begin
            check("ciphertext", ciphertext, exp_q[0].ct);
            // accept edge plus ten round edges
            check("latency", 128'(cyc - exp_q[0].acc), 128'd10);
            cur_ct <= exp_q[0].ct;
            void'(exp_q.pop_front());
          end
        end else begin
          check("ct_stable", ciphertext, cur_ct);
        end
        hold <= !out_ready;
        took <= out_ready;
      end else begin
        hold <= 1'b0;
        took <= 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic offer(input logic [127:0] p, input logic [127:0] k,
                       input logic [127:0] exp_ct, output int acc);
    int n = 0;
    plaintext = p;
    key       = k;
    in_valid  = 1'b1;
    acc       = -1;
    while (!(in_ready && !abort) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      check("offer_timeout", {127'h0, in_ready}, 128'h1);
    end else begin
      acc = cyc + 1;
      exp_q.push_back('{ct: exp_ct, acc: acc});
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    plaintext = rnd128();
    key       = rnd128();
  endtask

  task automatic run_rounds(input int pulse_at, input int abort_at, input int rst_at);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("round_idx", 128'(round_idx), 128'(i));
      check("busy", {127'h0, busy}, 128'h1);
      check("in_ready_busy", {127'h0, in_ready}, 128'h0);
      if (i == pulse_at) begin
        in_valid  = 1'b1;
        plaintext = rnd128();
        key       = rnd128();
      end else begin
        in_valid = 1'b0;
      end
      if (i == abort_at) begin
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_busy", {127'h0, busy}, 128'h0);
        check("abort_round_idx", 128'(round_idx), 128'h0);
        check("abort_out_valid", {127'h0, out_valid}, 128'h0);
        check("abort_in_ready", {127'h0, in_ready}, 128'h1);
        return;
      end
      if (i == rst_at) begin
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {127'h0, out_valid}, 128'h0);
        check("arst_busy", {127'h0, busy}, 128'h0);
        check("arst_round_idx", 128'(round_idx), 128'h0);
        check("arst_ciphertext", ciphertext, 128'h0);
        check("arst_in_ready", {127'h0, in_ready}, 128'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_block(input int stall);
    out_ready = (stall == 0);
    @(negedge clk);
    check("out_valid_rise", {127'h0, out_valid}, 128'h1);
    for (int s = 0; s < stall; s++) begin
      check("in_ready_stall", {127'h0, in_ready}, 128'h0);
      @(posedge clk);
      #1;
      if (s == stall - 1) out_ready = 1'b1;
      @(negedge clk);
      check("out_valid_hold", {127'h0, out_valid}, 128'h1);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check("out_valid_taken", {127'h0, out_valid}, 128'h0);
  endtask

  task automatic c1_run();
    int a;
    offer(FIPS_C1_PT, FIPS_C1_KEY, FIPS_C1_CT, a);
    run_rounds(0, 0, 0);
    finish_block(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    logic [127:0] p, k;
    build_sbox();
    rst = 1'b1; in_valid = 1'b0; plaintext = 128'h0; key = 128'h0;
    abort = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {127'h0, out_valid}, 128'h0);
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_round_idx", 128'(round_idx), 128'h0);
    check("rst_ciphertext", ciphertext, 128'h0);
    check("rst_in_ready", {127'h0, in_ready}, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {127'h0, in_ready}, 128'h1);

    // abort wins over accept while idle
    in_valid = 1'b1; abort = 1'b1; plaintext = rnd128(); key = rnd128();
    @(posedge clk);
    #1;
    in_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", {127'h0, busy}, 128'h0);

    c1_run();

    offer(FIPS_B_PT, FIPS_B_KEY, FIPS_B_CT, a0);
    run_rounds(0, 0, 0);
    finish_block(5);

    // back-to-back: second accept on the edge the first result is consumed
    out_ready = 1'b1;
    offer(FIPS_C1_PT, FIPS_C1_KEY, FIPS_C1_CT, a0);
    run_rounds(0, 0, 0);
    offer(FIPS_B_PT, FIPS_B_KEY, FIPS_B_CT, a1);
    check("b2b_spacing", 128'(a1 - a0), 128'd11);
    run_rounds(0, 0, 0);
    finish_block(0);

    p = rnd128(); k = rnd128();
    offer(p, k, ref_encrypt(p, k), a0);
    run_rounds(0, 5, 0);
    c1_run();

    p = rnd128(); k = rnd128();
    offer(p, k, ref_encrypt(p, k), a0);
    run_rounds(0, 0, 7);
    c1_run();

    offer(FIPS_C1_PT, FIPS_C1_KEY, FIPS_C1_CT, a0);
    run_rounds(3, 0, 0);
    finish_block(0);

    // abort discards a pending result even with out_ready low
    p = rnd128(); k = rnd128();
    offer(p, k, ref_encrypt(p, k), a0);
    run_rounds(0, 0, 0);
    out_ready = 1'b0;
    @(negedge clk);
    check("done_out_valid", {127'h0, out_valid}, 128'h1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("done_abort_out_valid", {127'h0, out_valid}, 128'h0);
    check("done_abort_in_ready", {127'h0, in_ready}, 128'h1);
    out_ready = 1'b1;

    for (int b = 0; b < 6; b++) begin
      p = rnd128(); k = rnd128();
      offer(p, k, ref_encrypt(p, k), a0);
      run_rounds(int'($urandom_range(0, 9)), 0, 0);
      finish_block(int'($urandom_range(0, 3)));
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
